// File: rtl/iopage_master.sv
// CPU-side master for the 8 KB I/O page: decodes, sequences ADDR/STROBE/DONE and returns data or errors.
// Optional IOPAGE_NXM_TIMEOUT_EN: STROBE waits up to 8 cycles for dev_decode before reporting nxm.
module iopage_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [21:0] req_addr,
  input  logic        req_wr,
  input  logic        req_byte,
  input  logic [15:0] req_data,
  output logic        ack,
  output logic [15:0] rsp_data,
  output logic        nxm,
  output logic        odd_err,
  output logic        busy,
  output logic [12:0] iopage_addr,
  output logic [15:0] iopage_data,
  output logic        iopage_rd,
  output logic        iopage_wr,
  output logic        iopage_byte_op,
  input  logic        dev_decode,
  input  logic [15:0] dev_data
);

  typedef enum logic [1:0] {IDLE, ADDR, STROBE, DONE} state_t;

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic        ack_q, ack_d;
  logic [15:0] rsp_q, rsp_d;
  logic        nxm_q, nxm_d;
  logic        odd_q, odd_d;
  logic        busy_q, busy_d;
  logic [12:0] addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        rd_q, rd_d;
  logic        wrs_q, wrs_d;
  logic        byte_q, byte_d;
`ifdef IOPAGE_NXM_TIMEOUT_EN
  logic [2:0]  wait_q, wait_d;
`endif

  function automatic logic is_iopage(input logic [21:0] a);
    return &a[21:13];
  endfunction

  // Byte writes replicate the low byte so either bus lane carries it.
  function automatic logic [15:0] fmt_wdata(input logic [15:0] d, input logic b);
    return b ? {d[7:0], d[7:0]} : d;
  endfunction

  function automatic logic [15:0] fmt_rdata(input logic [15:0] d, input logic b);
    return b ? {8'h00, d[7:0]} : d;
  endfunction

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    ack_d   = 1'b0;
    rsp_d   = rsp_q;
    nxm_d   = 1'b0;
    odd_d   = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    byte_d  = byte_q;
    rd_d    = 1'b0;
    wrs_d   = 1'b0;
`ifdef IOPAGE_NXM_TIMEOUT_EN
    wait_d  = wait_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          if (!is_iopage(req_addr)) begin
            state_d = DONE;
            ack_d   = 1'b1;
            nxm_d   = 1'b1;
            rsp_d   = 16'h0000;
          end else if (!req_byte && req_addr[0]) begin
            state_d = DONE;
            ack_d   = 1'b1;
            odd_d   = 1'b1;
            rsp_d   = 16'h0000;
          end else begin
            state_d = ADDR;
            wr_d    = req_wr;
            addr_d  = req_addr[12:0];
            byte_d  = req_byte;
            data_d  = fmt_wdata(req_data, req_byte);
          end
        end
      end
      ADDR: begin
        state_d = STROBE;
        rd_d    = !wr_q;
        wrs_d   = wr_q;
`ifdef IOPAGE_NXM_TIMEOUT_EN
        wait_d  = 3'd0;
`endif
      end
      STROBE: begin
        if (dev_decode) begin
          state_d = DONE;
          ack_d   = 1'b1;
          rsp_d   = wr_q ? 16'h0000 : fmt_rdata(dev_data, byte_q);
`ifdef IOPAGE_NXM_TIMEOUT_EN
        end else if (wait_q != 3'd7) begin
          wait_d  = wait_q + 3'd1;
          rd_d    = !wr_q;
          wrs_d   = wr_q;
`endif
        end else begin
          state_d = DONE;
          ack_d   = 1'b1;
          nxm_d   = 1'b1;
          rsp_d   = 16'h0000;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      rsp_q   <= 16'h0000;
      nxm_q   <= 1'b0;
      odd_q   <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= 13'h0000;
      data_q  <= 16'h0000;
      rd_q    <= 1'b0;
      wrs_q   <= 1'b0;
      byte_q  <= 1'b0;
`ifdef IOPAGE_NXM_TIMEOUT_EN
      wait_q  <= 3'd0;
`endif
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      ack_q   <= ack_d;
      rsp_q   <= rsp_d;
      nxm_q   <= nxm_d;
      odd_q   <= odd_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      wrs_q   <= wrs_d;
      byte_q  <= byte_d;
`ifdef IOPAGE_NXM_TIMEOUT_EN
      wait_q  <= wait_d;
`endif
    end
  end

  assign ack            = ack_q;
  assign rsp_data       = rsp_q;
  assign nxm            = nxm_q;
  assign odd_err        = odd_q;
  assign busy           = busy_q;
  assign iopage_addr    = addr_q;
  assign iopage_data    = data_q;
  assign iopage_rd      = rd_q;
  assign iopage_wr      = wrs_q;
  assign iopage_byte_op = byte_q;

endmodule

// File: tb/tb_iopage_master.sv
// Directed vector bench for iopage_master: access table plus reset-abort and reset-held-request sequences.
module tb_iopage_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [21:0] req_addr;
  logic        req_wr;
  logic        req_byte;
  logic [15:0] req_data;
  logic        ack;
  logic [15:0] rsp_data;
  logic        nxm;
  logic        odd_err;
  logic        busy;
  logic [12:0] iopage_addr;
  logic [15:0] iopage_data;
  logic        iopage_rd;
  logic        iopage_wr;
  logic        iopage_byte_op;
  logic        dev_decode;
  logic [15:0] dev_data;

  iopage_master dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_wr(req_wr),
    .req_byte(req_byte), .req_data(req_data), .ack(ack), .rsp_data(rsp_data),
    .nxm(nxm), .odd_err(odd_err), .busy(busy), .iopage_addr(iopage_addr),
    .iopage_data(iopage_data), .iopage_rd(iopage_rd), .iopage_wr(iopage_wr),
    .iopage_byte_op(iopage_byte_op), .dev_decode(dev_decode), .dev_data(dev_data)
  );

  always #5 clk = ~clk;

`ifdef IOPAGE_NXM_TIMEOUT_EN
  localparam int TO_LAT = 10;
  localparam int TO_STB = 8;
`else
  localparam int TO_LAT = 3;
  localparam int TO_STB = 1;
`endif

  typedef struct {
    logic [21:0] addr;
    logic        wr;
    logic        byt;
    logic [15:0] data;
    logic        dec;
    logic [15:0] ddata;
    int          lat;
    int          rdc;
    int          wrc;
    logic [15:0] rsp;
    logic        nxm;
    logic        odd;
    logic [12:0] ia;
    logic [15:0] id;
  } vec_t;

  vec_t vecs [12];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int          lat, rdc, wrc;
    logic [12:0] a_s;
    logic [15:0] d_s, rsp_s;
    logic        bo_s, nxm_s, odd_s, overlap;
    lat = -1; rdc = 0; wrc = 0; a_s = '0; d_s = '0; rsp_s = '0;
    bo_s = 1'b0; nxm_s = 1'b0; odd_s = 1'b0; overlap = 1'b0;
    @(negedge clk);
    req = 1'b1; req_addr = v.addr; req_wr = v.wr; req_byte = v.byt; req_data = v.data;
    dev_decode = v.dec; dev_data = v.ddata;
    for (int cyc = 1; cyc <= 20 && lat < 0; cyc++) begin
      @(posedge clk); #1;
      if (iopage_rd) rdc++;
      if (iopage_wr) wrc++;
      if (iopage_rd || iopage_wr) begin
        a_s = iopage_addr; d_s = iopage_data; bo_s = iopage_byte_op;
      end
      if ((nxm && odd_err) || (iopage_rd && iopage_wr)) overlap = 1'b1;
      if (ack) begin
        lat = cyc; rsp_s = rsp_data; nxm_s = nxm; odd_s = odd_err; req = 1'b0;
      end
    end
    req = 1'b0;
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
    check($sformatf("v%0d_rd_cycles", idx), 32'(rdc), 32'(v.rdc));
    check($sformatf("v%0d_wr_cycles", idx), 32'(wrc), 32'(v.wrc));
    check($sformatf("v%0d_rsp_data", idx), 32'(rsp_s), 32'(v.rsp));
    check($sformatf("v%0d_nxm_odd", idx), {30'd0, nxm_s, odd_s}, {30'd0, v.nxm, v.odd});
    check($sformatf("v%0d_exclusive", idx), 32'(overlap), 32'd0);
    if (v.rdc + v.wrc > 0) begin
      check($sformatf("v%0d_iopage_addr", idx), 32'(a_s), 32'(v.ia));
      check($sformatf("v%0d_byte_op", idx), 32'(bo_s), 32'(v.byt));
    end
    if (v.wrc > 0) check($sformatf("v%0d_iopage_data", idx), 32'(d_s), 32'(v.id));
    @(posedge clk); #1;
    check($sformatf("v%0d_after_ack", idx), {30'd0, ack, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{22'o17773000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'o000137, 3, 1, 0, 16'o000137, 1'b0, 1'b0, 13'o13000, 16'h0000};
    vecs[1]  = '{22'o17777566, 1'b1, 1'b1, 16'o000101, 1'b1, 16'h0000, 3, 0, 1, 16'h0000, 1'b0, 1'b0, 13'o17566, 16'o040501};
    vecs[2]  = '{22'o17760000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h5555, TO_LAT, TO_STB, 0, 16'h0000, 1'b1, 1'b0, 13'o00000, 16'h0000};
    vecs[3]  = '{22'o00001000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h7777, 1, 0, 0, 16'h0000, 1'b1, 1'b0, 13'o00000, 16'h0000};
    vecs[4]  = '{22'o17773001, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h7777, 1, 0, 0, 16'h0000, 1'b0, 1'b1, 13'o00000, 16'h0000};
    vecs[5]  = '{22'o17777565, 1'b0, 1'b1, 16'h0000, 1'b1, 16'hABCD, 3, 1, 0, 16'h00CD, 1'b0, 1'b0, 13'o17565, 16'h0000};
    vecs[6]  = '{22'o17772300, 1'b1, 1'b0, 16'h1234, 1'b1, 16'h0000, 3, 0, 1, 16'h0000, 1'b0, 1'b0, 13'o12300, 16'h1234};
    vecs[7]  = '{22'o17772302, 1'b1, 1'b0, 16'hBEEF, 1'b1, 16'hFFFF, 3, 0, 1, 16'h0000, 1'b0, 1'b0, 13'o12302, 16'hBEEF};
    vecs[8]  = '{22'o17757776, 1'b1, 1'b1, 16'h0042, 1'b1, 16'h0000, 1, 0, 0, 16'h0000, 1'b1, 1'b0, 13'o00000, 16'h0000};
    vecs[9]  = '{22'o17777777, 1'b1, 1'b0, 16'h0042, 1'b1, 16'h0000, 1, 0, 0, 16'h0000, 1'b0, 1'b1, 13'o00000, 16'h0000};
    vecs[10] = '{22'o00000001, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1, 0, 0, 16'h0000, 1'b1, 1'b0, 13'o00000, 16'h0000};
    vecs[11] = '{22'o17760100, 1'b1, 1'b1, 16'h12AB, 1'b0, 16'h0000, TO_LAT, 0, TO_STB, 16'h0000, 1'b1, 1'b0, 13'o00100, 16'hABAB};

    reset = 1'b1; req = 1'b0; req_addr = '0; req_wr = 1'b0; req_byte = 1'b0;
    req_data = '0; dev_decode = 1'b0; dev_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state",
          {ack, nxm, odd_err, busy, iopage_rd, iopage_wr, iopage_byte_op, rsp_data, iopage_addr, iopage_data},
          32'd0);
    check("reset_state_hi", {16'd0, rsp_data}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Reset asserted while a read is in STROBE aborts it; req held through reset is taken afterwards.
    @(negedge clk);
    req = 1'b1; req_addr = 22'o17773000; req_wr = 1'b0; req_byte = 1'b0;
    dev_decode = 1'b1; dev_data = 16'o000137;
    @(posedge clk); #1;
    check("abort_addr_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check("abort_strobe_rd", {31'd0, iopage_rd}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_edge", {19'd0, iopage_rd, busy, ack, iopage_addr}, 32'd0);
    @(posedge clk); #1;
    check("reset_held_req", {30'd0, busy, ack}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    lat = -1;
    for (int cyc = 1; cyc <= 20 && lat < 0; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) check("post_reset_accept", {31'd0, busy}, 32'd1);
      if (ack) begin
        lat = cyc;
        req = 1'b0;
        check("post_reset_rsp", {15'd0, nxm, rsp_data}, {15'd0, 1'b0, 16'o000137});
      end
    end
    check("post_reset_latency", 32'(lat), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/iopage_master.md
IOPAGE_MASTER -- requirements
Module: iopage_master

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port req  input  1  CPU access request; held high until ack.
REQ-004 SHALL have port req_addr  input  22  physical byte address.
REQ-005 SHALL have port req_wr  input  1  1=write, 0=read.
REQ-006 SHALL have port req_byte  input  1  1=byte access, 0=word.
REQ-007 SHALL have port req_data  input  16  write data; byte writes use bits [7:0].
REQ-008 SHALL have port ack  output  1  one-cycle completion pulse.
REQ-009 SHALL have port rsp_data  output  16  read data, valid while ack=1.
REQ-010 SHALL have port nxm  output  1  non-existent-address error, valid while ack=1.
REQ-011 SHALL have port odd_err  output  1  word access at odd address, valid while ack=1.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port iopage_addr  output  13  I/O page offset to devices.
REQ-014 SHALL have port iopage_data  output  16  write data to devices.
REQ-015 SHALL have ports iopage_rd, iopage_wr, iopage_byte_op  output  1 each  device strobes and byte qualifier.
REQ-016 SHALL have port dev_decode  input  1  OR of all device decode outputs.
REQ-017 SHALL have port dev_data  input  16  OR of all device data outputs (already byte-aligned to [7:0] for byte reads).

Function
REQ-018 SHALL implement states IDLE, ADDR, STROBE, DONE; every output registered.
REQ-019 SHALL treat an address as I/O page iff req_addr[21:13] = all ones (17760000-17777777 octal).
REQ-020 In IDLE with req=1: SHALL latch address, data, wr, byte; if not I/O page, go DONE with nxm=1; if req_byte=0 and req_addr[0]=1, go DONE with odd_err=1; otherwise go ADDR.
REQ-021 ADDR SHALL drive iopage_addr=req_addr[12:0], iopage_byte_op=req_byte, iopage_data per REQ-024, strobes low; next state STROBE.
REQ-022 STROBE SHALL hold addr/data/byte_op stable and assert exactly one of iopage_rd/iopage_wr; when dev_decode=1 is sampled, capture data and go DONE.
REQ-023 Read capture SHALL be rsp_data=dev_data for word and {8'b0, dev_data[7:0]} for byte.
REQ-024 Byte write SHALL drive iopage_data={req_data[7:0], req_data[7:0]}; word write drives req_data unchanged.
REQ-025 DONE SHALL pulse ack for one cycle with strobes low, then return to IDLE; the next req is accepted in IDLE no earlier than the cycle after ack.
REQ-026 Normal-access latency SHALL be ack three cycles after req is sampled (IDLE->ADDR->STROBE->DONE); error-at-accept latency SHALL be one cycle.
REQ-027 Writes to read-only devices that decode SHALL complete normally with nxm=0.
REQ-028 rsp_data SHALL be 0 on ack for writes and error completions.
REQ-029 nxm and odd_err SHALL never be 1 together.

Reset
REQ-030 reset=1 SHALL force IDLE and set ack, nxm, odd_err, busy, iopage_rd, iopage_wr, iopage_byte_op to 0 and rsp_data, iopage_addr, iopage_data to 0 at the next edge.
REQ-031 Reset during ADDR, STROBE, or DONE SHALL abort the access with no ack issued; strobes drop at that edge.
REQ-032 req high during reset SHALL be accepted only in the first IDLE cycle after reset deasserts.

Configuration
REQ-033 Macro IOPAGE_NXM_TIMEOUT_EN: when defined, STROBE SHALL wait up to 8 cycles for dev_decode, then go DONE with nxm=1; when undefined, dev_decode=0 in the first STROBE cycle SHALL immediately give nxm=1.

Verification
REQ-034 Word read 17773000, dev_decode=1, dev_data=000137 -> iopage_addr=13'o13000, iopage_rd for 1 cycle, ack 3 cycles after req, rsp_data=000137, nxm=0.
REQ-035 Byte write 17777566, req_data=000101 -> iopage_wr=1, iopage_byte_op=1, iopage_data=040501, ack with rsp_data=0.
REQ-036 Word read 17760000 with dev_decode=0 -> nxm=1 after 8 STROBE cycles (macro defined) or after 1 STROBE cycle (undefined).
REQ-037 Read 00001000 -> ack with nxm=1 one cycle after req, no strobe ever asserted; word read 17773001 -> ack with odd_err=1, no strobe.
REQ-038 reset pulsed during STROBE of a read -> iopage_rd=0 and busy=0 next edge, no ack; next req completes normally.
